frame_payload_src: RTL
======================

Name: frame_payload_src

Overview:
Upstream payload source for the DAQ optical frame processor. It pulls one complete event from a first-word-fall-through event FIFO and requests a frame from the frame processor with VALID. After TX_ACK it streams a header word and then the payload on TXD, one word per clock. It enforces a maximum frame length and an inter-frame gap, and it flags FIFO underrun and truncation.

Parameters:
MAX_WORDS, 1024, max payload words per frame, header excluded; range 1..4095
IFG_CYCLES, 16, minimum cycles VALID stays low between frames; covers processor CRC/EOP/ROM-reset tail
ACK_TIMEOUT, 64, cycles to wait for TX_ACK before abandoning a request
HDR_TAG, 4'hA, upper nibble of the header word

Ports:
CLK  in  1  system clock
RST_B  in  1  asynchronous active-low reset
EVT_RDY  in  1  at least one complete event (terminated by FIFO_LAST) is in the FIFO
FIFO_DOUT  in  16  FWFT FIFO data
FIFO_LAST  in  1  FWFT flag: FIFO_DOUT is the final word of its event
FIFO_EMPTY  in  1  FIFO empty
FIFO_RDEN  out  1  pop the current FIFO word (combinational from state and FIFO_EMPTY)
TX_ACK  in  1  single-cycle pulse from the frame processor at start of frame
VALID  out  1  frame request / data valid to the frame processor (registered)
TXD  out  16  frame data word (registered)
SEQ  out  12  sequence number of the next frame
ERR_UNDERRUN  out  1  1-cycle pulse: FIFO empty mid-payload
ERR_TRUNC  out  1  1-cycle pulse: event longer than MAX_WORDS
ERR_TIMEOUT  out  1  1-cycle pulse: TX_ACK not received in time
SRC_STATE  out  3  state encoding for debug

Behaviour:
- Reset (RST_B=0, asynchronous): state IDLE. VALID=0, TXD=0, SEQ=0, all ERR_* = 0, word counter = 0, gap/timeout counters = 0. FIFO_RDEN=0.
- States and encodings:
  - IDLE=0
  - REQ=1
  - HDR=2
  - PAYLOAD=3
  - DRAIN=4
  - GAP=5
- IDLE: if EVT_RDY and !FIFO_EMPTY, go to REQ; VALID<=1, TXD<=0.
- REQ:
  - VALID stays 1; timeout counter increments each cycle.
  - TX_ACK sampled 1: go to HDR; TXD<=HDR_TAG concatenated with SEQ; VALID stays 1. This header is the first word the processor sees in its Data state.
  - Counter reaches ACK_TIMEOUT-1 with no TX_ACK: pulse ERR_TIMEOUT, VALID<=0, go to GAP. The event is not consumed.
- HDR: one cycle only, then go to PAYLOAD.
- PAYLOAD, per cycle:
  - FIFO_RDEN=!FIFO_EMPTY; TXD<=FIFO_DOUT; word counter increments.
  - FIFO_LAST popped: next cycle VALID<=0; SEQ<=SEQ+1 (wraps 4095->0); go to GAP.
  - Word counter reaches MAX_WORDS without LAST: pulse ERR_TRUNC; VALID<=0 next cycle; SEQ increments; go to DRAIN.
  - FIFO_EMPTY asserted: TXD<=16'hDEAD, no pop; pulse ERR_UNDERRUN; VALID<=0; SEQ increments; go to DRAIN. The frame ends early; VALID never gaps mid-frame.
- DRAIN:
  - VALID=0; FIFO_RDEN=!FIFO_EMPTY.
  - Discard words until FIFO_LAST is popped, then go to GAP.
  - FIFO empty: hold in DRAIN.
- GAP: VALID=0; count IFG_CYCLES, then return to IDLE. VALID is never reasserted earlier.
- Simultaneous events in PAYLOAD:
  - LAST on word number MAX_WORDS: a normal end, no ERR_TRUNC.
  - TX_ACK outside REQ: ignored.
- Latency:
  - TX_ACK to first header word on TXD: 1 cycle.
  - Per payload word: 1 cycle, FIFO pop to TXD.
  - VALID deasserts exactly 1 cycle after the last word is driven.
- Reset mid-frame: immediately VALID=0 and state IDLE. The partially read event remains in the FIFO; clearing it is upstream's responsibility.

Test Plan:
1. 3-word event (0x1111, 0x2222, 0x3333 with LAST), SEQ=0, TX_ACK 6 cycles after VALID rises:
   - TXD = 0xA000, 0x1111, 0x2222, 0x3333 on consecutive cycles; VALID falls the next cycle.
   - SEQ=1; VALID stays low ≥16 cycles.
2. MAX_WORDS=4, 6-word event:
   - TXD carries header + 4 words; ERR_TRUNC pulses once.
   - 2 words are drained from the FIFO; next frame header = 0xA001.
3. FIFO_EMPTY asserted after the 2nd payload word:
   - TXD=0xDEAD for one cycle, then VALID=0; ERR_UNDERRUN pulses.
   - DRAIN waits; the LAST word arriving later is discarded.
4. No TX_ACK for 64 cycles:
   - ERR_TIMEOUT pulses; VALID=0 for 16 cycles; request retried; FIFO untouched.
5. Back-to-back frames with SEQ preset to 4095 (via 4095 single-word events):
   - Header 0xAFFF, then 0xA000 on the following frame; gap ≥ IFG_CYCLES between frames.
6. RST_B low during PAYLOAD:
   - VALID, TXD, ERR_* go to 0 asynchronously; SRC_STATE=0.

Source files
------------

// File: rtl/frame_payload_src.sv
// frame_payload_src
//   Upstream payload source for the DAQ optical frame processor. Waits for a
//   complete event in a first-word-fall-through FIFO, raises VALID to request
//   a frame and waits for TX_ACK. It then streams a header word
//   {HDR_TAG, SEQ} followed by the event payload on TXD, one word per clock.
//   A frame is cut at MAX_WORDS payload words, and the rest of the event is
//   drained. If the FIFO runs dry mid-payload, the frame is closed with a
//   0xDEAD filler word. VALID then stays low for at least IFG_CYCLES before
//   the next request.
//
// Ports
//   CLK, RST_B          clock, asynchronous active-low reset
//   EVT_RDY             a complete event is present in the FIFO
//   FIFO_DOUT/LAST      FWFT head word and its end-of-event flag
//   FIFO_EMPTY          FIFO empty
//   FIFO_RDEN           pop the head word (combinational)
//   TX_ACK              start-of-frame pulse from the frame processor
//   VALID, TXD          registered frame request / data
//   SEQ                 sequence number carried by the next frame header
//   ERR_UNDERRUN        1-cycle pulse, FIFO ran empty mid-payload
//   ERR_TRUNC           1-cycle pulse, event longer than MAX_WORDS
//   ERR_TIMEOUT         1-cycle pulse, no TX_ACK within ACK_TIMEOUT cycles
//   SRC_STATE           current state encoding, for debug
module frame_payload_src #(
    parameter int         MAX_WORDS   = 1024,
    parameter int         IFG_CYCLES  = 16,
    parameter int         ACK_TIMEOUT = 64,
    parameter logic [3:0] HDR_TAG     = 4'hA
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        EVT_RDY,
    input  logic [15:0] FIFO_DOUT,
    input  logic        FIFO_LAST,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RDEN,
    input  logic        TX_ACK,
    output logic        VALID,
    output logic [15:0] TXD,
    output logic [11:0] SEQ,
    output logic        ERR_UNDERRUN,
    output logic        ERR_TRUNC,
    output logic        ERR_TIMEOUT,
    output logic [2:0]  SRC_STATE
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    localparam logic [11:0] LAST_WORD_IDX = 12'(MAX_WORDS - 1);
    localparam logic [15:0] ACK_LIMIT     = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LIMIT     = 16'(IFG_CYCLES);
    localparam logic [15:0] UNDERRUN_FILL = 16'hDEAD;

    state_t      state, state_nxt;
    logic        valid_nxt;
    logic [15:0] txd_nxt;
    logic [11:0] seq_nxt;
    logic        err_underrun_nxt, err_trunc_nxt, err_timeout_nxt;
    logic [11:0] wcnt, wcnt_nxt;
    logic [15:0] tcnt, tcnt_nxt;
    logic [15:0] gcnt, gcnt_nxt;

    assign SRC_STATE = state;

    always_comb begin
        state_nxt        = state;
        valid_nxt        = VALID;
        txd_nxt          = TXD;
        seq_nxt          = SEQ;
        err_underrun_nxt = 1'b0;
        err_trunc_nxt    = 1'b0;
        err_timeout_nxt  = 1'b0;
        wcnt_nxt         = wcnt;
        tcnt_nxt         = tcnt;
        gcnt_nxt         = gcnt;
        FIFO_RDEN        = 1'b0;

        case (state)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                if (EVT_RDY && !FIFO_EMPTY) begin
                    state_nxt = ST_REQ;
                    valid_nxt = 1'b1;
                    txd_nxt   = 16'h0000;
                    tcnt_nxt  = 16'h0000;
                end
            end

            ST_REQ: begin
                valid_nxt = 1'b1;
                if (TX_ACK) begin
                    state_nxt = ST_HDR;
                    txd_nxt   = {HDR_TAG, SEQ};
                    wcnt_nxt  = 12'h000;
                end else if (tcnt == ACK_LIMIT) begin
                    // Abandon the request; the event stays in the FIFO for a retry.
                    state_nxt       = ST_GAP;
                    valid_nxt       = 1'b0;
                    err_timeout_nxt = 1'b1;
                    gcnt_nxt        = 16'h0000;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end

            // The header is on TXD during HDR, so the first payload word is
            // popped in the same cycle. This keeps header and payload on
            // consecutive clocks.
            ST_HDR, ST_PAYLOAD: begin
                state_nxt = ST_PAYLOAD;
                if (FIFO_EMPTY) begin
                    state_nxt        = ST_DRAIN;
                    txd_nxt          = UNDERRUN_FILL;
                    err_underrun_nxt = 1'b1;
                    seq_nxt          = SEQ + 12'd1;
                end else begin
                    FIFO_RDEN = 1'b1;
                    txd_nxt   = FIFO_DOUT;
                    wcnt_nxt  = wcnt + 12'd1;
                    // LAST takes priority, so an event of exactly MAX_WORDS is a normal end.
                    if (FIFO_LAST) begin
                        state_nxt = ST_GAP;
                        seq_nxt   = SEQ + 12'd1;
                        gcnt_nxt  = 16'h0000;
                    end else if (wcnt == LAST_WORD_IDX) begin
                        state_nxt     = ST_DRAIN;
                        err_trunc_nxt = 1'b1;
                        seq_nxt       = SEQ + 12'd1;
                    end
                end
            end

            // VALID is dropped one cycle after the final word was placed on TXD.
            ST_DRAIN: begin
                valid_nxt = 1'b0;
                if (!FIFO_EMPTY) begin
                    FIFO_RDEN = 1'b1;
                    if (FIFO_LAST) begin
                        state_nxt = ST_GAP;
                        gcnt_nxt  = 16'h0000;
                    end
                end
            end

            ST_GAP: begin
                valid_nxt = 1'b0;
                if (gcnt == GAP_LIMIT) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gcnt_nxt = gcnt + 16'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Register stage: state, outputs and counters.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state        <= ST_IDLE;
            VALID        <= 1'b0;
            TXD          <= 16'h0000;
            SEQ          <= 12'h000;
            ERR_UNDERRUN <= 1'b0;
            ERR_TRUNC    <= 1'b0;
            ERR_TIMEOUT  <= 1'b0;
            wcnt         <= 12'h000;
            tcnt         <= 16'h0000;
            gcnt         <= 16'h0000;
        end else begin
            state        <= state_nxt;
            VALID        <= valid_nxt;
            TXD          <= txd_nxt;
            SEQ          <= seq_nxt;
            ERR_UNDERRUN <= err_underrun_nxt;
            ERR_TRUNC    <= err_trunc_nxt;
            ERR_TIMEOUT  <= err_timeout_nxt;
            wcnt         <= wcnt_nxt;
            tcnt         <= tcnt_nxt;
            gcnt         <= gcnt_nxt;
        end
    end

endmodule
